// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - multi-cycle RV32M multiply/divide sequencer with tagged valid/ready response
module mdu_sequencer #(
  parameter bit FAST_DIV_SPECIAL = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [4:0]  req_op_i,
  input  logic [31:0] req_a_i,
  input  logic [31:0] req_b_i,
  input  logic [4:0]  req_rd_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_result_o,
  output logic [4:0]  resp_rd_o,
  input  logic        flush_i,
  output logic        busy_o
);
  localparam logic [4:0] OP_MUL    = 5'b01010;
  localparam logic [4:0] OP_MULH   = 5'b01011;
  localparam logic [4:0] OP_MULHSU = 5'b01100;
  localparam logic [4:0] OP_MULHU  = 5'b01101;
  localparam logic [4:0] OP_DIV    = 5'b01110;
  localparam logic [4:0] OP_REM    = 5'b10000;
  localparam logic [4:0] OP_REMU   = 5'b10001;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e      state_q;
  logic        resp_valid_q;
  logic [31:0] resp_result_q;
  logic [4:0]  resp_rd_q;
  logic [4:0]  rd_q;
  logic [31:0] opa_q;
  logic [31:0] opb_q;
  logic [31:0] rem_q;
  logic [4:0]  cnt_q;
  logic        mul_hi_q, mul_sa_q, mul_sb_q;
  logic        neg_q_q, neg_r_q, sel_rem_q;

  logic        req_is_mul, req_is_div, req_signed, req_is_rem;
  logic        req_b_zero, req_ovf, req_special;
  logic [31:0] req_special_res, req_a_abs, req_b_abs;

  assign req_is_mul = (req_op_i >= OP_MUL) && (req_op_i <= OP_MULHU);
  assign req_is_div = (req_op_i >= OP_DIV) && (req_op_i <= OP_REMU);
  assign req_signed = (req_op_i == OP_DIV) || (req_op_i == OP_REM);
  assign req_is_rem = (req_op_i == OP_REM) || (req_op_i == OP_REMU);
  assign req_b_zero = (req_b_i == 32'd0);
  assign req_ovf    = req_signed && (req_a_i == 32'h8000_0000) && (req_b_i == 32'hFFFF_FFFF);
  assign req_special = req_b_zero || req_ovf;
  assign req_special_res = req_b_zero ? (req_is_rem ? req_a_i : 32'hFFFF_FFFF)
                                      : (req_is_rem ? 32'd0 : 32'h8000_0000);
  assign req_a_abs = (req_signed && req_a_i[31]) ? (~req_a_i + 32'd1) : req_a_i;
  assign req_b_abs = (req_signed && req_b_i[31]) ? (~req_b_i + 32'd1) : req_b_i;

  // In MUL opa_q/opb_q hold the operands; in DIV opa_q is the dividend/quotient shifter, opb_q the divisor.
  logic signed [63:0] mul_a_ext, mul_b_ext, prod_d;
  assign mul_a_ext = {{32{mul_sa_q & opa_q[31]}}, opa_q};
  assign mul_b_ext = {{32{mul_sb_q & opb_q[31]}}, opb_q};
  assign prod_d    = mul_a_ext * mul_b_ext;

  // Restoring step: a borrow out of the 33-bit trial means the divisor did not fit.
  logic [32:0] trial_d;
  logic        fits_d;
  logic [31:0] rem_d, quo_d, quo_fix_d, rem_fix_d;
  assign trial_d   = {rem_q, opa_q[31]} - {1'b0, opb_q};
  assign fits_d    = ~trial_d[32];
  assign rem_d     = fits_d ? trial_d[31:0] : {rem_q[30:0], opa_q[31]};
  assign quo_d     = {opa_q[30:0], fits_d};
  assign quo_fix_d = neg_q_q ? (~quo_d + 32'd1) : quo_d;
  assign rem_fix_d = neg_r_q ? (~rem_d + 32'd1) : rem_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      resp_valid_q  <= 1'b0;
      resp_result_q <= 32'd0;
      resp_rd_q     <= 5'd0;
      rd_q          <= 5'd0;
      opa_q         <= 32'd0;
      opb_q         <= 32'd0;
      rem_q         <= 32'd0;
      cnt_q         <= 5'd0;
      mul_hi_q      <= 1'b0;
      mul_sa_q      <= 1'b0;
      mul_sb_q      <= 1'b0;
      neg_q_q       <= 1'b0;
      neg_r_q       <= 1'b0;
      sel_rem_q     <= 1'b0;
    end else if (flush_i) begin
      state_q      <= S_IDLE;
      resp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            rd_q <= req_rd_i;
            if (req_is_mul) begin
              opa_q    <= req_a_i;
              opb_q    <= req_b_i;
              mul_hi_q <= (req_op_i != OP_MUL);
              mul_sa_q <= (req_op_i == OP_MULH) || (req_op_i == OP_MULHSU);
              mul_sb_q <= (req_op_i == OP_MULH);
              state_q  <= S_MUL;
            end else if (req_is_div && !(FAST_DIV_SPECIAL && req_special)) begin
              opa_q     <= req_a_abs;
              opb_q     <= req_b_abs;
              rem_q     <= 32'd0;
              cnt_q     <= 5'd0;
              neg_q_q   <= req_signed && (req_a_i[31] ^ req_b_i[31]) && !req_b_zero;
              neg_r_q   <= req_signed && req_a_i[31];
              sel_rem_q <= req_is_rem;
              state_q   <= S_DIV;
            end else begin
              resp_result_q <= req_is_div ? req_special_res : 32'd0;
              resp_rd_q     <= req_rd_i;
              resp_valid_q  <= 1'b1;
              state_q       <= S_DONE;
            end
          end
        end
        S_MUL: begin
          resp_result_q <= mul_hi_q ? prod_d[63:32] : prod_d[31:0];
          resp_rd_q     <= rd_q;
          resp_valid_q  <= 1'b1;
          state_q       <= S_DONE;
        end
        S_DIV: begin
          opa_q <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            resp_result_q <= sel_rem_q ? rem_fix_d : quo_fix_d;
            resp_rd_q     <= rd_q;
            resp_valid_q  <= 1'b1;
            state_q       <= S_DONE;
          end
        end
        S_DONE: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o   = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign resp_valid_o  = resp_valid_q;
  assign resp_result_o = resp_result_q;
  assign resp_rd_o     = resp_rd_q;
endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - scoreboard bench for mdu_sequencer against an arithmetic reference model
module tb_mdu_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_op = 5'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_result;
  logic [4:0]  resp_rd;
  logic        flush = 1'b0;
  logic        busy;

  mdu_sequencer dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_a_i(req_a), .req_b_i(req_b), .req_rd_i(req_rd),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_result_o(resp_result), .resp_rd_o(resp_rd),
    .flush_i(flush), .busy_o(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic prev_v = 1'b0;
  logic rr_auto = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    logic ovf;
    sa  = longint'(signed'(a));
    sb  = longint'(signed'(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      5'd10: begin p = sa * sb; return p[31:0];  end
      5'd11: begin p = sa * sb; return p[63:32]; end
      5'd12: begin p = sa * ub; return p[63:32]; end
      5'd13: begin p = ua * ub; return p[63:32]; end
      5'd14: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(signed'(a) / signed'(b));
      5'd15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd16: return (b == 0) ? a : ovf ? 32'd0 : 32'(signed'(a) % signed'(b));
      5'd17: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    sgn = (op == 5'd14) || (op == 5'd16);
    if (op >= 5'd10 && op <= 5'd13) return 2;
    if (op >= 5'd14 && op <= 5'd17) begin
      if (b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
      return 33;
    end
    return 1;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the acceptance edge.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int acc);
    exp_t e;
    int n;
    n = 0;
    while (!req_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("issue_ready", {31'd0, req_ready}, 32'd1);
    acc = -1;
    if (req_ready) begin
      req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_rd = rd;
      @(posedge clk); #1;
      req_valid = 1'b0;
      acc   = cyc;
      e.res = model(op, a, b);
      e.rd  = rd;
      e.lat = model_lat(op, a, b);
      e.acc = acc;
      exp_q.push_back(e);
    end
  endtask

  always begin
    @(posedge clk); #1;
    if (rr_auto) resp_ready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      if (!prev_v) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_resp: got result %h rd %0d with empty scoreboard", resp_result, resp_rd);
        end else begin
          cur = exp_q.pop_front();
          chk("latency", 32'(cyc - cur.acc + 1), 32'(cur.lat));
        end
      end
      chk("resp_result", resp_result, cur.res);
      chk("resp_rd", {27'd0, resp_rd}, {27'd0, cur.rd});
      chk("req_ready_in_done", {31'd0, req_ready}, 32'd0);
      chk("busy_in_done", {31'd0, busy}, 32'd1);
    end
    prev_v = resp_valid;
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_resp_result"}, resp_result, 32'd0);
    chk({tag, "_resp_rd"}, {27'd0, resp_rd}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  vec_t dir[$];

  initial begin
    int acc, hs, n;
    logic [4:0]  op;
    logic [31:0] a, b;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    dir.push_back('{5'd10, 32'd7,          32'hFFFF_FFFD});
    dir.push_back('{5'd11, 32'h8000_0000, 32'h8000_0000});
    dir.push_back('{5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    dir.push_back('{5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    dir.push_back('{5'd14, 32'hFFFF_FFF9, 32'd2});
    dir.push_back('{5'd16, 32'hFFFF_FFF9, 32'd2});
    dir.push_back('{5'd15, 32'hFFFF_FFF9, 32'd2});
    dir.push_back('{5'd14, 32'd55,         32'd0});
    dir.push_back('{5'd17, 32'h1234,       32'd0});
    dir.push_back('{5'd14, 32'h8000_0000, 32'hFFFF_FFFF});
    dir.push_back('{5'd16, 32'h8000_0000, 32'hFFFF_FFFF});
    dir.push_back('{5'd3,  32'd99,         32'd4});
    foreach (dir[i]) issue(dir[i].op, dir[i].a, dir[i].b, 5'(i + 1), acc);

    // Backpressure: hold the response for 5 cycles, then release and re-issue immediately.
    n = 0;
    while (!req_ready && n < 300) begin @(posedge clk); #1; n++; end
    rr_auto = 1'b0;
    resp_ready = 1'b0;
    issue(5'd10, 32'd123, 32'd456, 5'd17, acc);
    n = 0;
    while (!resp_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("bp_valid_seen", {31'd0, resp_valid}, 32'd1);
    repeat (5) @(posedge clk);
    #1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    hs = cyc;
    chk("bp_valid_dropped", {31'd0, resp_valid}, 32'd0);
    chk("bp_idle_after_hs", {31'd0, req_ready}, 32'd1);
    issue(5'd13, 32'hDEAD_BEEF, 32'h1234_5678, 5'd18, acc);
    chk("bp_accept_gap", 32'(acc - hs), 32'd1);
    rr_auto = 1'b1;

    // Flush at T+10 of a divide; a request offered during a flush is refused.
    issue(5'd14, 32'd100000, 32'd7, 5'd9, acc);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    void'(exp_q.pop_back());
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_ready", {31'd0, req_ready}, 32'd1);
    chk("flush_valid", {31'd0, resp_valid}, 32'd0);
    flush = 1'b1;
    req_valid = 1'b1; req_op = 5'd10; req_a = 32'd3; req_b = 32'd3; req_rd = 5'd2;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    chk("flush_refuses_req", {31'd0, busy}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    issue(5'd10, 32'hFFFF_FFFE, 32'd21, 5'd21, acc);

    // Reset in the middle of a divide.
    issue(5'd15, 32'd12345, 32'd67, 5'd5, acc);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(exp_q.pop_back());
    check_reset_outputs("midrst");

    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31)) : 5'(10 + $urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 20));
        3: b = -32'($urandom_range(1, 20));
        default: ;
      endcase
      issue(op, a, b, 5'($urandom_range(0, 31)), acc);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end

    n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 500) begin @(posedge clk); #1; n++; end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Multi-cycle sequencer for the RV32M multiply/divide operations, taking them off the single-cycle ALU critical path. It sits beside the execute-stage ALU. It accepts one M-extension operation at a time over a valid/ready handshake, using the same 5-bit operation codes the ALU control already produces. It returns a tagged 32-bit result over a second valid/ready handshake. Multiply uses a registered product; divide/remainder uses a 32-iteration restoring divider. The pipeline stalls on `busy`.

## Interface
- `FAST_DIV_SPECIAL`, default 1: 1 means divide-by-zero and signed overflow skip the iteration; 0 means they run the full 32 iterations. Results are identical either way.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE.
- `req_op` in 5: operation code.
  - 01010 MUL, 01011 MULH, 01100 MULHSU, 01101 MULHU.
  - 01110 DIV, 01111 DIVU, 10000 REM, 10001 REMU.
- `req_a` in 32: rs1 operand.
- `req_b` in 32: rs2 operand.
- `req_rd` in 5: destination tag, returned unchanged.
- `resp_valid` out 1: result present.
- `resp_ready` in 1: consumer accepts the result.
- `resp_result` out 32: result.
- `resp_rd` out 5: tag of the result.
- `flush` in 1: abort; any in-flight operation is discarded.
- `busy` out 1: high whenever state is not IDLE.

## Operation
- States: IDLE, MUL, DIV, DONE.
- All outputs are registered.
- IDLE:
  - Accept on `req_valid && req_ready`; latch op, operands and tag.
  - Multiply codes go to MUL.
  - Divide/remainder codes go to DIV. Special cases go directly to DONE when `FAST_DIV_SPECIAL=1`.
  - Any other code goes to DONE with result 0.
- MUL: one cycle; the 64-bit product is registered, then the state moves to DONE.
  - MUL returns product[31:0].
  - MULH treats a and b as signed; MULHSU treats a as signed and b as unsigned; MULHU treats both as unsigned. All three return product[63:32].
- DIV:
  - Signed ops (DIV, REM) load |a| and |b| and record the result signs.
    - Quotient is negated if sign(a) differs from sign(b).
    - Remainder takes the sign of a.
  - 5-bit iteration counter, one quotient bit per cycle, MSB first, 32 cycles.
  - On the last iteration the sign fix is applied, the result is registered, and the state moves to DONE.
- Special divide results:
  - b=0: DIV/DIVU return FFFFFFFF; REM/REMU return a.
  - a=80000000, b=FFFFFFFF, signed op: DIV returns 80000000; REM returns 0.
- DONE:
  - `resp_valid`=1; `resp_result` and `resp_rd` are held stable until `resp_ready`.
  - On the response handshake the state moves to IDLE and `resp_valid` drops on the next edge.
  - A new request cannot be accepted in the same cycle as the response handshake.
- `flush`:
  - In any state, moves to IDLE on the next edge with `resp_valid`=0.
  - Takes priority over request acceptance and response handshake.
  - A request presented in a flush cycle is not accepted.
- `rst` has priority over everything; it is honoured mid-operation.

## Timing
- Reset values: state IDLE; `req_ready`=1; `resp_valid`=0; `resp_result`=0; `resp_rd`=0; `busy`=0.
- Acceptance edge is T.
- Latencies (edges after T at which `resp_valid` first reads 1):
  - Multiply: T+2.
  - Normal divide: T+33.
  - Special divide with `FAST_DIV_SPECIAL=1`: T+1.
  - Unknown op: T+1.
- `busy` is 1 from T+1 until the edge that completes the response handshake.
- Back-to-back throughput: one operation per latency + 1 cycles minimum (an IDLE cycle is needed to accept the next request).
- `req_ready` is combinational from state only: `req_ready` = (state==IDLE). It has no dependence on `req_valid`.

## Test plan
- MUL a=7, b=FFFFFFFD -> FFFFFFEB at T+2.
- MULH, MULHSU and MULHU (T+2 each):
  - MULH 80000000×80000000 -> 40000000.
  - MULHSU FFFFFFFF×FFFFFFFF -> FFFFFFFF.
  - MULHU FFFFFFFF×FFFFFFFF -> FFFFFFFE.
- Signed and unsigned divide (each at T+33):
  - DIV a=FFFFFFF9 (-7), b=2 -> FFFFFFFD.
  - REM same operands -> FFFFFFFF.
  - DIVU a=FFFFFFF9, b=2 -> 7FFFFFFC.
- Special cases (each at T+1 with `FAST_DIV_SPECIAL=1`):
  - DIV by 0 -> FFFFFFFF; REMU a=1234, b=0 -> 1234.
  - DIV 80000000/FFFFFFFF -> 80000000; REM same operands -> 0.
- Backpressure: hold `resp_ready`=0 for 5 cycles after `resp_valid` -> `resp_result`/`resp_rd` stable, `req_ready`=0. Then `resp_ready`=1 -> IDLE next edge and a new request is accepted one cycle later.
- `flush` at T+10 of a DIV -> IDLE at T+11 with no response produced. A subsequent MUL returns the correct result and tag.
- `rst` asserted mid-DIV -> all outputs at reset values on the next edge.
